// File: rtl/rc4_prga_stream.sv
// RC4 keystream (PRGA) engine: walks the encrypted ROM, swaps S entries, writes plaintext to D RAM
// and optionally screens each plaintext symbol against a printable window.
module rc4_prga_stream #(
  parameter int DATA_W       = 8,
  parameter int MSG_LEN      = 32,
  parameter int K_W          = $clog2(MSG_LEN),
  parameter int RD_LAT       = 2,
  parameter bit CHECK_EN     = 1'b1,
  parameter bit ABORT_ON_BAD = 1'b1,
  parameter int CHAR_LO      = 97,
  parameter int CHAR_HI      = 122,
  parameter int CHAR_SP      = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              key_valid_o,
  output logic [K_W-1:0]    fail_idx_o,
  output logic [DATA_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_wdata_o,
  output logic              s_wren_o,
  input  logic [DATA_W-1:0] s_rdata_i,
  output logic [K_W-1:0]    e_addr_o,
  input  logic [DATA_W-1:0] e_rdata_i,
  output logic [K_W-1:0]    d_addr_o,
  output logic [DATA_W-1:0] d_wdata_o,
  output logic              d_wren_o
);

  typedef enum logic [3:0] {
    IDLE, RD_I, RD_J, WR_I, WR_J, RD_F, WR_D, CHECK, DONE
  } state_t;

  localparam logic [K_W-1:0] LAST_K = K_W'(MSG_LEN - 1);
  localparam logic [1:0]     LAT_M  = 2'(RD_LAT);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, pt_q, pt_d;
  logic [K_W-1:0]    k_q, k_d, badIdx_q, badIdx_d;
  logic [1:0]        wait_q, wait_d;
  logic              badSeen_q, badSeen_d;
  logic              busy_q, busy_d, done_q, done_d, keyValid_q, keyValid_d;
  logic [K_W-1:0]    failIdx_q, failIdx_d, eAddr_q, eAddr_d, dAddr_q, dAddr_d;
  logic [DATA_W-1:0] sAddr_q, sAddr_d, sWdata_q, sWdata_d, dWdata_q, dWdata_d;
  logic              sWren_q, sWren_d, dWren_q, dWren_d;
  logic              waitDone, ptOk, checkBad;

  assign waitDone = (wait_q == LAT_M);
  assign ptOk     = ((pt_q >= DATA_W'(CHAR_LO)) && (pt_q <= DATA_W'(CHAR_HI)))
                    || (pt_q == DATA_W'(CHAR_SP));
  assign checkBad = CHECK_EN && !ptOk;

  // Every bus is loaded on the edge that enters the state using it, so outputs are pure registers.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    pt_d       = pt_q;
    k_d        = k_q;
    badIdx_d   = badIdx_q;
    badSeen_d  = badSeen_q;
    wait_d     = wait_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    keyValid_d = keyValid_q;
    failIdx_d  = failIdx_q;
    sAddr_d    = sAddr_q;
    sWdata_d   = sWdata_q;
    sWren_d    = 1'b0;
    eAddr_d    = eAddr_q;
    dAddr_d    = dAddr_q;
    dWdata_d   = dWdata_q;
    dWren_d    = 1'b0;
    case (state_q)
      IDLE: begin
        i_d       = '0;
        j_d       = '0;
        k_d       = '0;
        badSeen_d = 1'b0;
        wait_d    = '0;
        if (start_i) begin
          i_d        = DATA_W'(1);
          sAddr_d    = DATA_W'(1);
          busy_d     = 1'b1;
          keyValid_d = 1'b0;
          failIdx_d  = '0;
          state_d    = RD_I;
        end
      end
      RD_I: begin
        if (waitDone) begin
          si_d    = s_rdata_i;
          j_d     = j_q + s_rdata_i;
          sAddr_d = j_q + s_rdata_i;
          wait_d  = '0;
          state_d = RD_J;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      RD_J: begin
        if (waitDone) begin
          sj_d     = s_rdata_i;
          sAddr_d  = i_q;
          sWdata_d = s_rdata_i;
          sWren_d  = 1'b1;
          wait_d   = '0;
          state_d  = WR_I;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      WR_I: begin
        // Writing S[j] second means S[i] keeps si when i == j.
        sAddr_d  = j_q;
        sWdata_d = si_q;
        sWren_d  = 1'b1;
        state_d  = WR_J;
      end
      WR_J: begin
        sAddr_d = si_q + sj_q;
        eAddr_d = k_q;
        state_d = RD_F;
      end
      RD_F: begin
        if (waitDone) begin
          pt_d     = s_rdata_i ^ e_rdata_i;
          dAddr_d  = k_q;
          dWdata_d = s_rdata_i ^ e_rdata_i;
          dWren_d  = 1'b1;
          wait_d   = '0;
          state_d  = WR_D;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      WR_D: state_d = CHECK;
      CHECK: begin
        if (checkBad && !badSeen_q) begin
          badSeen_d = 1'b1;
          badIdx_d  = k_q;
        end
        if ((checkBad && ABORT_ON_BAD) || (k_q == LAST_K)) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + K_W'(1);
          i_d     = i_q + DATA_W'(1);
          sAddr_d = i_q + DATA_W'(1);
          state_d = RD_I;
        end
      end
      DONE: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        keyValid_d = CHECK_EN ? !badSeen_q : 1'b1;
        failIdx_d  = badSeen_q ? badIdx_q : LAST_K;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      si_q       <= '0;
      sj_q       <= '0;
      pt_q       <= '0;
      k_q        <= '0;
      badIdx_q   <= '0;
      badSeen_q  <= 1'b0;
      wait_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      keyValid_q <= 1'b0;
      failIdx_q  <= '0;
      sAddr_q    <= '0;
      sWdata_q   <= '0;
      sWren_q    <= 1'b0;
      eAddr_q    <= '0;
      dAddr_q    <= '0;
      dWdata_q   <= '0;
      dWren_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      pt_q       <= pt_d;
      k_q        <= k_d;
      badIdx_q   <= badIdx_d;
      badSeen_q  <= badSeen_d;
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      keyValid_q <= keyValid_d;
      failIdx_q  <= failIdx_d;
      sAddr_q    <= sAddr_d;
      sWdata_q   <= sWdata_d;
      sWren_q    <= sWren_d;
      eAddr_q    <= eAddr_d;
      dAddr_q    <= dAddr_d;
      dWdata_q   <= dWdata_d;
      dWren_q    <= dWren_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign key_valid_o = keyValid_q;
  assign fail_idx_o  = failIdx_q;
  assign s_addr_o    = sAddr_q;
  assign s_wdata_o   = sWdata_q;
  assign s_wren_o    = sWren_q;
  assign e_addr_o    = eAddr_q;
  assign d_addr_o    = dAddr_q;
  assign d_wdata_o   = dWdata_q;
  assign d_wren_o    = dWren_q;

endmodule

// File: tb/tb_rc4_prga_stream.sv
// Bench for rc4_prga_stream: six parameter variants, each with its own S/E/D memory models,
// checked against hand vectors and a reference RC4 model.
module tb_rc4_prga_stream;

  localparam int NINST = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       startV[NINST];
  logic       doneV[NINST], busyV[NINST], keyValidV[NINST], otherOutsV[NINST];
  logic [7:0] failIdxV[NINST];
  int         dWritesV[NINST];
  logic [7:0] dViewV[NINST][32];
  logic [7:0] sView3[256];
  logic [5:0] loadMask = '0;
  logic       loadS = 1'b0, loadE = 1'b0;
  logic [7:0] loadAddr = '0, loadData = '0;

  // 0: check off, 1: check+abort, 2: check no-abort, 3: 32-byte identity, 4: RD_LAT=1, 5: RD_LAT=3
  for (genvar g = 0; g < NINST; g++) begin : g_dut
    localparam int ML  = (g == 3) ? 32 : 9;
    localparam int KW  = $clog2(ML);
    localparam int LAT = (g == 4) ? 1 : ((g == 5) ? 3 : 2);
    localparam bit CE  = (g == 1) || (g == 2);
    localparam bit AB  = (g != 2);

    logic          busy, done, keyValid, sWren, dWren;
    logic [KW-1:0] failIdx, eAddr, dAddr;
    logic [7:0]    sAddr, sWdata, sRdata, eRdata, dWdata;
    logic [7:0]    sMem[256];
    logic [7:0]    eMem[32];
    logic [7:0]    dMem[32];
    logic [7:0]    sPipe[LAT];
    logic [7:0]    ePipe[LAT];
    int            dWrites = 0;

    rc4_prga_stream #(
      .DATA_W(8), .MSG_LEN(ML), .K_W(KW), .RD_LAT(LAT), .CHECK_EN(CE),
      .ABORT_ON_BAD(AB), .CHAR_LO(97), .CHAR_HI(122), .CHAR_SP(32)
    ) dut (
      .clk_i(clk), .reset_i(reset), .start_i(startV[g]),
      .busy_o(busy), .done_o(done), .key_valid_o(keyValid), .fail_idx_o(failIdx),
      .s_addr_o(sAddr), .s_wdata_o(sWdata), .s_wren_o(sWren), .s_rdata_i(sRdata),
      .e_addr_o(eAddr), .e_rdata_i(eRdata),
      .d_addr_o(dAddr), .d_wdata_o(dWdata), .d_wren_o(dWren)
    );

    always @(posedge clk) begin
      if (loadS && loadMask[g]) sMem[loadAddr] <= loadData;
      else if (sWren) sMem[sAddr] <= sWdata;
      if (loadE && loadMask[g]) eMem[loadAddr[4:0]] <= loadData;
      if (dWren) begin
        dMem[dAddr] <= dWdata;
        dWrites <= dWrites + 1;
      end
      sPipe[0] <= sMem[sAddr];
      ePipe[0] <= eMem[eAddr];
      for (int p = 1; p < LAT; p++) begin
        sPipe[p] <= sPipe[p-1];
        ePipe[p] <= ePipe[p-1];
      end
    end

    assign sRdata        = sPipe[LAT-1];
    assign eRdata        = ePipe[LAT-1];
    assign doneV[g]      = done;
    assign busyV[g]      = busy;
    assign keyValidV[g]  = keyValid;
    assign failIdxV[g]   = 8'(failIdx);
    assign dWritesV[g]   = dWrites;
    assign otherOutsV[g] = busy | done | sWren | dWren | (|sAddr) | (|sWdata)
                           | (|eAddr) | (|dAddr) | (|dWdata);
    for (genvar x = 0; x < 32; x++) begin : g_dv
      assign dViewV[g][x] = dMem[x];
    end
    if (g == 3) begin : g_sv
      for (genvar x = 0; x < 256; x++) begin : g_x
        assign sView3[x] = sMem[x];
      end
    end
  end

  int nCompared = 0;
  int nMismatched = 0;

  logic [7:0] modelS[256];
  logic [7:0] modelKs[32];
  logic [7:0] ptKey[9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] ctKey[9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

  typedef struct {
    int inst;
    int expLat;
    bit expKv;
    int expFi;
    int expWrites;
    int nBytes;
  } vec_t;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic modelKsa();
    logic [7:0] key[3] = '{8'h4B, 8'h65, 8'h79};
    logic [7:0] j = 8'h00;
    logic [7:0] t;
    for (int x = 0; x < 256; x++) modelS[x] = 8'(x);
    for (int x = 0; x < 256; x++) begin
      j = j + modelS[x] + key[x % 3];
      t = modelS[x];
      modelS[x] = modelS[j];
      modelS[j] = t;
    end
  endtask

  task automatic modelPrga(input int n);
    logic [7:0] i = 8'h00;
    logic [7:0] j = 8'h00;
    logic [7:0] t;
    for (int k = 0; k < n; k++) begin
      i = i + 8'd1;
      j = j + modelS[i];
      t = modelS[i];
      modelS[i] = modelS[j];
      modelS[j] = t;
      t = modelS[i] + modelS[j];
      modelKs[k] = modelS[t];
    end
  endtask

  task automatic loadSMem(input logic [5:0] mask);
    @(negedge clk);
    loadMask = mask;
    loadS = 1'b1;
    for (int x = 0; x < 256; x++) begin
      loadAddr = 8'(x);
      loadData = modelS[x];
      @(negedge clk);
    end
    loadS = 1'b0;
  endtask

  task automatic loadEMem(input logic [5:0] mask, input bit useKey);
    @(negedge clk);
    loadMask = mask;
    loadE = 1'b1;
    for (int x = 0; x < 32; x++) begin
      loadAddr = 8'(x);
      loadData = (useKey && x < 9) ? ctKey[x] : 8'h00;
      @(negedge clk);
    end
    loadE = 1'b0;
  endtask

  // Latency counts edges after the edge that sampled start until done is seen.
  task automatic applyStimulus(input int g, input int maxCyc, output int lat, output bit seen,
                               output bit busyEarly);
    seen = 1'b0;
    lat = 0;
    busyEarly = 1'b0;
    @(negedge clk);
    startV[g] = 1'b1;
    @(posedge clk);
    #1 startV[g] = 1'b0;
    while (!seen && lat < maxCyc) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) busyEarly = busyV[g];
      if (doneV[g]) seen = 1'b1;
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[5];
    int   lat, w0, firstDone, pulses;
    bit   seen, busyEarly;

    vecs[0] = '{0, 118, 1'b1, 8, 9, 9};
    vecs[1] = '{1, 14,  1'b0, 0, 1, 1};
    vecs[2] = '{2, 118, 1'b0, 0, 9, 9};
    vecs[3] = '{4, 91,  1'b1, 8, 9, 9};
    vecs[4] = '{5, 145, 1'b1, 8, 9, 9};

    for (int g = 0; g < NINST; g++) startV[g] = 1'b0;

    modelKsa();
    loadSMem(6'b110111);
    loadEMem(6'b110111, 1'b1);
    for (int x = 0; x < 256; x++) modelS[x] = 8'(x);
    loadSMem(6'b001000);
    loadEMem(6'b001000, 1'b0);

    for (int g = 0; g < NINST; g++) begin
      checkOutput($sformatf("reset_outs_inst%0d", g), 32'(otherOutsV[g]), 0);
      checkOutput($sformatf("reset_keyvalid_inst%0d", g), 32'(keyValidV[g]), 0);
      checkOutput($sformatf("reset_failidx_inst%0d", g), 32'(failIdxV[g]), 0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int r = 0; r < 5; r++) begin
      int g;
      g = vecs[r].inst;
      w0 = dWritesV[g];
      applyStimulus(g, 200, lat, seen, busyEarly);
      checkOutput($sformatf("row%0d_done_seen", r), 32'(seen), 1);
      checkOutput($sformatf("row%0d_done_latency", r), lat, vecs[r].expLat);
      checkOutput($sformatf("row%0d_busy_early", r), 32'(busyEarly), 1);
      checkOutput($sformatf("row%0d_busy_at_done", r), 32'(busyV[g]), 0);
      checkOutput($sformatf("row%0d_key_valid", r), 32'(keyValidV[g]), 32'(vecs[r].expKv));
      checkOutput($sformatf("row%0d_fail_idx", r), 32'(failIdxV[g]), vecs[r].expFi);
      checkOutput($sformatf("row%0d_d_writes", r), dWritesV[g] - w0, vecs[r].expWrites);
      for (int b = 0; b < vecs[r].nBytes; b++)
        checkOutput($sformatf("row%0d_d%0d", r, b), 32'(dViewV[g][b]), 32'(ptKey[b]));
      @(negedge clk);
      checkOutput($sformatf("row%0d_done_one_cycle", r), 32'(doneV[g]), 0);
    end

    // Identity S with a start pulse injected while busy.
    modelPrga(32);
    firstDone = 0;
    pulses = 0;
    @(negedge clk);
    startV[3] = 1'b1;
    @(posedge clk);
    #1 startV[3] = 1'b0;
    for (int c = 1; c <= 460; c++) begin
      @(posedge clk);
      @(negedge clk);
      startV[3] = (c == 30);
      if (doneV[3]) begin
        pulses++;
        if (firstDone == 0) firstDone = c;
      end
    end
    startV[3] = 1'b0;
    checkOutput("ident_done_latency", firstDone, 417);
    checkOutput("ident_done_pulses", pulses, 1);
    checkOutput("ident_key_valid", 32'(keyValidV[3]), 1);
    checkOutput("ident_fail_idx", 32'(failIdxV[3]), 31);
    checkOutput("ident_d0_hand", 32'(dViewV[3][0]), 2);
    for (int b = 0; b < 32; b++)
      checkOutput($sformatf("ident_d%0d", b), 32'(dViewV[3][b]), 32'(modelKs[b]));

    // Reset sampled on the 20th edge of a run, then a clean rerun from whatever S holds.
    @(negedge clk);
    startV[3] = 1'b1;
    @(posedge clk);
    #1 startV[3] = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    checkOutput("midrun_busy", 32'(busyV[3]), 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrun_reset_outs", 32'(otherOutsV[3]), 0);
    checkOutput("midrun_reset_keyvalid", 32'(keyValidV[3]), 0);
    checkOutput("midrun_reset_failidx", 32'(failIdxV[3]), 0);
    reset = 1'b0;
    @(negedge clk);
    for (int x = 0; x < 256; x++) modelS[x] = sView3[x];
    modelPrga(32);
    applyStimulus(3, 600, lat, seen, busyEarly);
    checkOutput("rerun_done_seen", 32'(seen), 1);
    checkOutput("rerun_done_latency", lat, 417);
    for (int b = 0; b < 32; b++)
      checkOutput($sformatf("rerun_d%0d", b), 32'(dViewV[3][b]), 32'(modelKs[b]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
